// File: rtl/relu_grad_mask.sv
// Records one ReLU pass bit per forward activation and zeroes the matching returning gradient, in order.
// Latency 1 cycle bwd->gout; gout holds until gout_ready, fwd stalls when full, bwd stalls when empty or output blocked.
module relu_grad_mask #(
  parameter int DW    = 24,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          fwd_valid,
  output logic          fwd_ready,
  input  logic [DW-1:0] fwd_din,
  input  logic          bwd_valid,
  output logic          bwd_ready,
  input  logic [DW-1:0] bwd_grad,
  output logic          gout_valid,
  input  logic          gout_ready,
  output logic [DW-1:0] gout_data,
  output logic [AW:0]   mask_count,
  output logic          err_under
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DEPTH-1:0] mask_q, mask_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             gout_valid_q, gout_valid_d;
  logic [DW-1:0]    gout_data_q, gout_data_d;
  logic             err_q, err_d;
  logic             push, pop;

  assign fwd_ready  = (count_q != FULL_CNT);
  assign bwd_ready  = (count_q != '0) & (~gout_valid_q | gout_ready);
  assign push       = fwd_valid & fwd_ready;
  assign pop        = bwd_valid & bwd_ready;

  assign gout_valid = gout_valid_q;
  assign gout_data  = gout_data_q;
  assign mask_count = count_q;
  assign err_under  = err_q;

  always_comb begin
    mask_d       = mask_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    gout_valid_d = gout_valid_q;
    gout_data_d  = gout_data_q;
    err_d        = err_q;

    // Zero activation counts as passed, matching the forward ReLU.
    if (push) begin
      mask_d[wr_ptr_q] = en & ~fwd_din[DW-1];
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      gout_valid_d = 1'b1;
      gout_data_d  = mask_q[rd_ptr_q] ? bwd_grad : '0;
    end else if (gout_ready) begin
      gout_valid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (bwd_valid && (count_q == '0)) err_d = 1'b1;

    if (clr) begin
      mask_d       = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      gout_valid_d = 1'b0;
      gout_data_d  = '0;
      err_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      gout_valid_q <= 1'b0;
      gout_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      mask_q       <= mask_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      gout_valid_q <= gout_valid_d;
      gout_data_q  <= gout_data_d;
      err_q        <= err_d;
    end
  end

endmodule
